// File: rtl/coord_pkg.sv
// Shared constants and types for the core coordinator: stall codes, message bit positions,
// core id type.
package coord_pkg;

  localparam int unsigned NCORES_MAX = 4;

  localparam logic [2:0] STALL_NONE = 3'd0;
  localparam logic [2:0] STALL_LOAD = 3'd4;
  localparam logic [2:0] STALL_WB   = 3'd6;

  localparam int unsigned PR_VALID  = 3;
  localparam int unsigned PR_RESUME = 2;
  localparam int unsigned PCO_VALID = 18;

  typedef logic [1:0] core_id_t;

  // Successor of a core id, wrapping at the configured core count.
  function automatic core_id_t next_id(input core_id_t id, input int unsigned n);
    return core_id_t'((32'(id) + 32'd1) % n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; one-hot grant plus encoded id.
module rr_arbiter
  import coord_pkg::*;
#(
  parameter int unsigned NCORES = 4
) (
  input  logic [NCORES-1:0] req,
  input  core_id_t          ptr,
  output logic [NCORES-1:0] grant,
  output core_id_t          grant_id,
  output logic              any
);

  core_id_t idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      idx = core_id_t'((32'(ptr) + k) % NCORES);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/core_coordinator.sv
// Shared data-memory arbiter and inter-core pause/resume/awaken router for NCORES cores.
// Optional stall statistics counter enabled by defining COORD_STATS_EN.
module core_coordinator
  import coord_pkg::*;
#(
  parameter int unsigned NCORES  = 4,
  parameter logic [15:0] BOOT_PC = 16'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCORES-1:0]    awake,
  input  logic [NCORES-1:0]    ld_req,
  input  logic [NCORES*15-1:0] ld_addr,
  input  logic [NCORES-1:0]    st_req,
  input  logic [NCORES*15-1:0] st_addr,
  input  logic [NCORES*16-1:0] st_data,
  input  logic [NCORES*4-1:0]  pause_resume,
  input  logic [NCORES*19-1:0] pc_out,
  output logic [NCORES*3-1:0]  stall_num,
  output logic [NCORES*17-1:0] pc_passed,
  output logic [NCORES*18-1:0] core_rdata,
  output logic                 mem_ren,
  output logic [14:0]          mem_raddr,
  input  logic [15:0]          mem_rdata,
  output logic                 mem_wen,
  output logic [14:0]          mem_waddr,
  output logic [15:0]          mem_wdata
`ifdef COORD_STATS_EN
  ,
  input  logic [1:0]           stat_sel,
  output logic [15:0]          stat_count
`endif
);

  logic [NCORES-1:0] paused_q, paused_d;
  core_id_t          rr_ptr_q;
  logic              boot_pending_q;
  logic              rd_valid_q;
  core_id_t          rd_id_q;
  logic [NCORES-1:0] pcv_q, pcv_d;
  logic [15:0]       pc_q [NCORES];
  logic [15:0]       pc_d [NCORES];
  logic [15:0]       boot_pc_val;

  logic [NCORES-1:0] st_elig, ld_elig, st_grant, ld_grant;
  core_id_t          st_id, ld_id;
  logic              st_any, ld_any, ld_win;

  // Requests are ignored entirely while reset is high.
  assign st_elig = st_req & awake & ~paused_q & {NCORES{~reset}};
  assign ld_elig = ld_req & awake & ~paused_q & {NCORES{~reset}};
  assign ld_win  = ld_any & ~st_any;

  rr_arbiter #(.NCORES(NCORES)) u_st_arb (
    .req      (st_elig),
    .ptr      (rr_ptr_q),
    .grant    (st_grant),
    .grant_id (st_id),
    .any      (st_any)
  );

  rr_arbiter #(.NCORES(NCORES)) u_ld_arb (
    .req      (ld_elig),
    .ptr      (rr_ptr_q),
    .grant    (ld_grant),
    .grant_id (ld_id),
    .any      (ld_any)
  );

  always_comb begin
    mem_wen   = st_any;
    mem_waddr = st_addr[15*st_id +: 15];
    mem_wdata = st_data[16*st_id +: 16];
    mem_ren   = ld_win;
    mem_raddr = ld_addr[15*ld_id +: 15];
  end

  always_comb begin
    stall_num = '0;
    for (int i = 0; i < NCORES; i++) begin
      stall_num[3*i +: 3] = STALL_NONE;
      if (!reset) begin
        if (paused_q[i] || (st_elig[i] && !st_grant[i])) begin
          stall_num[3*i +: 3] = STALL_WB;
        end else if (ld_elig[i] && !(ld_win && ld_grant[i])) begin
          stall_num[3*i +: 3] = STALL_LOAD;
        end
      end
    end
  end

  logic        pause_hit, clear_hit, awk_hit;
  logic [15:0] awk_pc;

  always_comb begin
    paused_d    = paused_q;
    pcv_d       = '0;
    pc_d        = pc_q;
    boot_pc_val = BOOT_PC;
    pause_hit   = 1'b0;
    clear_hit   = 1'b0;
    awk_hit     = 1'b0;
    awk_pc      = '0;
    for (int t = 0; t < NCORES; t++) begin
      pause_hit = 1'b0;
      clear_hit = 1'b0;
      awk_hit   = 1'b0;
      awk_pc    = '0;
      for (int s = 0; s < NCORES; s++) begin
        if (pause_resume[4*s+PR_VALID] && pause_resume[4*s +: 2] == core_id_t'(t)) begin
          if (pause_resume[4*s+PR_RESUME]) clear_hit = 1'b1;
          else                             pause_hit = 1'b1;
        end
        // Ascending scan: the lowest-numbered source claims the target first.
        if (!awk_hit && pc_out[19*s+PCO_VALID] && pc_out[19*s+16 +: 2] == core_id_t'(t)) begin
          awk_hit = 1'b1;
          awk_pc  = pc_out[19*s +: 16];
        end
      end
      if (awk_hit || clear_hit) paused_d[t] = 1'b0;
      else if (pause_hit)       paused_d[t] = 1'b1;
      pcv_d[t] = awk_hit;
      pc_d[t]  = awk_pc;
      // An awaken of core 0 during the boot cycle replaces the boot PC in that same pulse.
      if (t == 0 && boot_pending_q && awk_hit) begin
        pcv_d[0]    = 1'b0;
        boot_pc_val = awk_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paused_q       <= '0;
      rr_ptr_q       <= '0;
      boot_pending_q <= 1'b1;
      rd_valid_q     <= 1'b0;
      rd_id_q        <= '0;
      pcv_q          <= '0;
      for (int i = 0; i < NCORES; i++) pc_q[i] <= '0;
    end else begin
      paused_q       <= paused_d;
      boot_pending_q <= 1'b0;
      rd_valid_q     <= ld_win;
      rd_id_q        <= ld_id;
      pcv_q          <= pcv_d;
      for (int i = 0; i < NCORES; i++) pc_q[i] <= pc_d[i];
      if (st_any)      rr_ptr_q <= next_id(st_id, NCORES);
      else if (ld_win) rr_ptr_q <= next_id(ld_id, NCORES);
    end
  end

  always_comb begin
    pc_passed  = '0;
    core_rdata = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (!reset) begin
        pc_passed[17*i +: 17] = {pcv_q[i], pc_q[i]};
        if (rd_valid_q && rd_id_q == core_id_t'(i)) core_rdata[18*i +: 18] = {2'b10, mem_rdata};
      end
    end
    if (!reset && boot_pending_q) pc_passed[16:0] = {1'b1, boot_pc_val};
  end

`ifdef COORD_STATS_EN
  logic [15:0] stat_q;
  logic [3:0]  stall_nz;

  always_comb begin
    stall_nz = '0;
    for (int i = 0; i < NCORES; i++) stall_nz[i] = |stall_num[3*i +: 3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else if (stall_nz[stat_sel] && stat_q != 16'hFFFF) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_count = stat_q;
`endif

endmodule
